// File: rtl/fp_assemble_pipe.sv
// Final assembly stage of the FP multiplier: picks special/overflow/rounded word, adds flags,
// and delivers through a two-deep valid/ready pipeline with sticky flags and an overflow counter.
module fp_assemble_pipe #(
    parameter int WEXP = 8,
    parameter int WSIG = 23,
    parameter int TAGW = 4,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WSIG-1:0]      roundprod,
    input  logic [WEXP-1:0]      shiftexp,
    input  logic                 sign,
    input  logic [WEXP+WSIG-1:0] special,
    input  logic                 specialsign,
    input  logic                 specialcase,
    input  logic                 specialsigncase,
    input  logic [1:0]           roundmode,
    input  logic                 overflow,
    input  logic                 underflow_in,
    input  logic                 inexact_in,
    input  logic [TAGW-1:0]      in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WEXP+WSIG:0]   y,
    output logic [TAGW-1:0]      out_tag,
    output logic [3:0]           out_flags,
    output logic [3:0]           sticky_flags,
    input  logic                 flags_clear,
    output logic [CNTW-1:0]      ovf_count
);
    localparam int W = WEXP + WSIG + 1;

    localparam logic [W-2:0] INF_WORD     = {{WEXP{1'b1}}, {WSIG{1'b0}}};
    localparam logic [W-2:0] LARGEST_WORD = {{(WEXP-1){1'b1}}, 1'b0, {WSIG{1'b1}}};

    logic           sel_sign;
    logic           use_largest;
    logic [W-2:0]   sel_word;
    logic [3:0]     sel_flags;

    logic           valid_a;
    logic [W-1:0]   word_a;
    logic [TAGW-1:0] tag_a;
    logic [3:0]     flags_a;

    logic           adv_b;
    logic           deliv;
    logic           deliv_ovf;

    always_comb begin
        sel_sign    = specialsigncase ? specialsign : sign;
        use_largest = roundmode[1] ? (sel_sign ^ roundmode[0]) : roundmode[0];
        if (specialcase)
            sel_word = special;
        else if (overflow)
            sel_word = use_largest ? LARGEST_WORD : INF_WORD;
        else
            sel_word = {shiftexp, roundprod};
        // {special, inexact, underflow, overflow}
        sel_flags = {specialcase,
                     (inexact_in | overflow) & ~specialcase,
                     underflow_in & ~specialcase & ~overflow,
                     overflow & ~specialcase};
    end

    assign adv_b     = ~out_valid | out_ready;
    assign in_ready  = ~valid_a | adv_b;
    assign deliv     = out_valid & out_ready;
    assign deliv_ovf = deliv & out_flags[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_a <= 1'b0;
            word_a  <= '0;
            tag_a   <= '0;
            flags_a <= '0;
        end else if (in_ready) begin
            valid_a <= in_valid;
            if (in_valid) begin
                word_a  <= {sel_sign, sel_word};
                tag_a   <= in_tag;
                flags_a <= sel_flags;
            end
        end
    end

    // Output registers only load on a real beat so y holds through bubbles and stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv_b) begin
            out_valid <= valid_a;
            if (valid_a) begin
                y         <= word_a;
                out_tag   <= tag_a;
                out_flags <= flags_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_flags <= '0;
            ovf_count    <= '0;
        end else begin
            if (flags_clear)
                sticky_flags <= deliv ? out_flags : 4'b0000;
            else if (deliv)
                sticky_flags <= sticky_flags | out_flags;

            if (flags_clear)
                ovf_count <= deliv_ovf ? CNTW'(1) : '0;
            else if (deliv_ovf && ovf_count != {CNTW{1'b1}})
                ovf_count <= ovf_count + CNTW'(1);
        end
    end
endmodule

// File: tb/tb_fp_assemble_pipe.sv
// Directed self-checking bench for fp_assemble_pipe; a CNTW=2 copy checks counter saturation.
module tb_fp_assemble_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [22:0] roundprod;
    logic [7:0]  shiftexp;
    logic        sign;
    logic [30:0] special;
    logic        specialsign, specialcase, specialsigncase;
    logic [1:0]  roundmode;
    logic        overflow, underflow_in, inexact_in;
    logic [3:0]  in_tag;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] y, y2;
    logic [3:0]  out_tag, out_tag2;
    logic [3:0]  out_flags, out_flags2;
    logic [3:0]  sticky_flags, sticky_flags2;
    logic        flags_clear;
    logic [15:0] ovf_count;
    logic [1:0]  ovf_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_assemble_pipe #(.WEXP(8), .WSIG(23), .TAGW(4), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .roundprod(roundprod), .shiftexp(shiftexp), .sign(sign), .special(special),
        .specialsign(specialsign), .specialcase(specialcase), .specialsigncase(specialsigncase),
        .roundmode(roundmode), .overflow(overflow), .underflow_in(underflow_in),
        .inexact_in(inexact_in), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_tag(out_tag), .out_flags(out_flags), .sticky_flags(sticky_flags),
        .flags_clear(flags_clear), .ovf_count(ovf_count)
    );

    fp_assemble_pipe #(.WEXP(8), .WSIG(23), .TAGW(4), .CNTW(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .roundprod(roundprod), .shiftexp(shiftexp), .sign(sign), .special(special),
        .specialsign(specialsign), .specialcase(specialcase), .specialsigncase(specialsigncase),
        .roundmode(roundmode), .overflow(overflow), .underflow_in(underflow_in),
        .inexact_in(inexact_in), .in_tag(in_tag), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .out_tag(out_tag2), .out_flags(out_flags2), .sticky_flags(sticky_flags2),
        .flags_clear(flags_clear), .ovf_count(ovf_count2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_beat(input logic s, input logic [7:0] e, input logic [22:0] m,
                            input logic ovf, input logic [1:0] rm);
        sign = s; shiftexp = e; roundprod = m; overflow = ovf; roundmode = rm;
        special = '0; specialsign = 0; specialcase = 0; specialsigncase = 0;
        underflow_in = 0; inexact_in = 0; in_tag = '0;
    endtask

    // Single beat through an empty pipe with out_ready=1; checks 2-cycle latency.
    task automatic run_one(input string tag, input logic [31:0] exp_y,
                           input logic [3:0] exp_f, input logic clr);
        in_valid = 1;
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_y"}, y, exp_y);
        check({tag, "_flags"}, {28'b0, out_flags}, {28'b0, exp_f});
        flags_clear = clr;
        @(posedge clk); @(negedge clk);
        flags_clear = 0;
    endtask

    logic [31:0] ovf_y [8] = '{32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F7FFFFF,
                              32'hFF800000, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000};
    logic [3:0]  ready_pat = 4'b1001;

    initial begin
        reset = 1; in_valid = 0; out_ready = 1; flags_clear = 0;
        set_beat(0, 8'h00, 23'h0, 0, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_tag_flags", {24'b0, out_tag, out_flags}, 32'd0);
        check("rst_sticky_cnt", {12'b0, sticky_flags, ovf_count}, 32'd0);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // overflow rounding table
        for (int i = 0; i < 8; i++) begin
            set_beat(i[2], 8'h12, 23'h1234, 1, i[1:0]);
            run_one($sformatf("ovf%0d", i), ovf_y[i], 4'b0101, 0);
        end
        check("ovf_cnt8", {16'b0, ovf_count}, 32'd8);
        check("sticky_ovf", {28'b0, sticky_flags}, 32'h5);

        set_beat(0, 8'h7F, 23'h0, 0, 2'b00);
        run_one("normal", 32'h3F800000, 4'b0000, 0);

        set_beat(0, 8'h55, 23'h55, 1, 2'b01);
        special = 31'h7FC00000; specialcase = 1; specialsigncase = 1; specialsign = 1;
        inexact_in = 1; underflow_in = 1;
        run_one("special", 32'hFFC00000, 4'b1000, 0);
        check("sticky_spec", {28'b0, sticky_flags}, 32'hD);

        set_beat(1, 8'h01, 23'h7, 0, 2'b00);
        underflow_in = 1; inexact_in = 1;
        run_one("unf", 32'h80800007, 4'b0110, 0);

        set_beat(0, 8'h01, 23'h7, 1, 2'b00);
        underflow_in = 1;
        run_one("ovf_unf", 32'h7F800000, 4'b0101, 0);

        flags_clear = 1;
        @(posedge clk); @(negedge clk);
        flags_clear = 0;
        check("clr_sticky", {28'b0, sticky_flags}, 32'd0);
        check("clr_cnt", {16'b0, ovf_count}, 32'd0);
        check("clr_cnt2", {30'b0, ovf_count2}, 32'd0);

        // three overflows, then clear coincident with the fourth delivery
        set_beat(0, 8'h10, 23'h0, 1, 2'b00);
        for (int i = 0; i < 3; i++) run_one("cnt", 32'h7F800000, 4'b0101, 0);
        check("cnt3", {16'b0, ovf_count}, 32'd3);
        check("cnt3_sat", {30'b0, ovf_count2}, 32'd3);
        run_one("cnt_clr", 32'h7F800000, 4'b0101, 1);
        check("clr_deliv_cnt", {16'b0, ovf_count}, 32'd1);
        check("clr_deliv_sticky", {28'b0, sticky_flags}, 32'h5);
        check("clr_deliv_cnt2", {30'b0, ovf_count2}, 32'd1);
        for (int i = 0; i < 4; i++) run_one("sat", 32'h7F800000, 4'b0101, 0);
        check("cnt5", {16'b0, ovf_count}, 32'd5);
        check("cnt2_sat", {30'b0, ovf_count2}, 32'd3);

        // streaming with backpressure
        begin
            int nt = 0, ne = 0, cyc = 0;
            logic stalled = 0;
            logic [31:0] held_y = 0;
            logic [3:0] held_tag = 0;
            while (ne < 10 && cyc < 200) begin
                out_ready = ready_pat[cyc % 4];
                if (nt < 10) begin
                    set_beat(0, 8'(nt + 1), 23'(nt * 3), 0, 2'b00);
                    in_tag = 4'(nt);
                    in_valid = 1;
                end else in_valid = 0;
                #1;
                if (stalled) begin
                    check("stall_y", y, held_y);
                    check("stall_tag", {28'b0, out_tag}, {28'b0, held_tag});
                end
                if (out_valid && out_ready) begin
                    check("strm_tag", {28'b0, out_tag}, 32'(ne));
                    check("strm_y", y, {1'b0, 8'(ne + 1), 23'(ne * 3)});
                    ne++;
                end
                stalled = out_valid & ~out_ready;
                held_y = y; held_tag = out_tag;
                if (in_valid && in_ready) nt++;
                @(posedge clk); @(negedge clk);
                cyc++;
            end
            check("strm_count", 32'(ne), 32'd10);
            in_valid = 0; out_ready = 1;
            @(posedge clk); @(negedge clk);
        end

        // reset with both stages full
        out_ready = 0;
        set_beat(0, 8'h20, 23'h1, 1, 2'b00);
        in_valid = 1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        check("full_valid", {31'b0, out_valid}, 32'd1);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1;
        @(posedge clk); @(negedge clk);
        reset = 0; out_ready = 1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_cnt", {16'b0, ovf_count}, 32'd0);
        check("mid_rst_sticky", {28'b0, sticky_flags}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("mid_rst_drained", {31'b0, out_valid}, 32'd0);
        set_beat(0, 8'h7F, 23'h0, 0, 2'b00);
        run_one("post_rst", 32'h3F800000, 4'b0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
